// File: rtl/ps2_pkg.sv
// PS/2 keyboard shared definitions: frame states, set-2 prefix bytes and the
// scancode-to-key-code translation table used by ps2_keyb_rx.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Key codes for non-printing extended keys
    localparam logic [7:0] KEY_UP    = 8'h80;
    localparam logic [7:0] KEY_DOWN  = 8'h81;
    localparam logic [7:0] KEY_LEFT  = 8'h82;
    localparam logic [7:0] KEY_RIGHT = 8'h83;

    // {extended, scancode} -> key code; 8'h00 means unmapped
    function automatic logic [7:0] scan2ascii(input logic [8:0] code);
        logic [7:0] key;
        key = 8'h00;
        case (code)
            9'h01C: key = 8'h41;  9'h032: key = 8'h42;  9'h021: key = 8'h43;
            9'h023: key = 8'h44;  9'h024: key = 8'h45;  9'h02B: key = 8'h46;
            9'h034: key = 8'h47;  9'h033: key = 8'h48;  9'h043: key = 8'h49;
            9'h03B: key = 8'h4A;  9'h042: key = 8'h4B;  9'h04B: key = 8'h4C;
            9'h03A: key = 8'h4D;  9'h031: key = 8'h4E;  9'h044: key = 8'h4F;
            9'h04D: key = 8'h50;  9'h015: key = 8'h51;  9'h02D: key = 8'h52;
            9'h01B: key = 8'h53;  9'h02C: key = 8'h54;  9'h03C: key = 8'h55;
            9'h02A: key = 8'h56;  9'h01D: key = 8'h57;  9'h022: key = 8'h58;
            9'h035: key = 8'h59;  9'h01A: key = 8'h5A;
            9'h045: key = 8'h30;  9'h016: key = 8'h31;  9'h01E: key = 8'h32;
            9'h026: key = 8'h33;  9'h025: key = 8'h34;  9'h02E: key = 8'h35;
            9'h036: key = 8'h36;  9'h03D: key = 8'h37;  9'h03E: key = 8'h38;
            9'h046: key = 8'h39;
            9'h05A: key = 8'h0D;  9'h029: key = 8'h20;  9'h066: key = 8'h08;
            9'h076: key = 8'h1B;
            9'h175: key = KEY_UP;    9'h172: key = KEY_DOWN;
            9'h16B: key = KEY_LEFT;  9'h174: key = KEY_RIGHT;
            default: key = 8'h00;
        endcase
        return key;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises and filters the raw pins,
// runs the 11-bit frame FSM on filtered falling clock edges, aborts stalled frames.
// Ports: clk_i, res_n_i (async active-low), ps2_clk_i/ps2_data_i (raw pins),
//        byte_v/byte_o (1-cycle strobe + received byte), err (1-cycle error pulse).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk_i,
    input  logic       res_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_v,
    output logic [7:0] byte_o,
    output logic       err
);
    localparam int unsigned FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_s;
    logic                   clk_filt;
    logic [FILT_W-1:0]      filt_cnt;
    logic                   fe;
    logic                   data_s;

    frame_state_e           state_q, state_d;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shreg_q;
    logic                   par_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic                   timeout_c;
    logic                   byte_v_d, err_d;

    // Pin synchronisers; idle bus level is high
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_i};
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];

    // Clock glitch filter; data is captured together with the falling-edge strobe
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fe       <= 1'b0;
            data_s   <= 1'b1;
        end else begin
            fe <= 1'b0;
            if (clk_s == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
                filt_cnt <= '0;
                clk_filt <= clk_s;
                fe       <= clk_filt;
                data_s   <= data_sync[SYNC_STAGES-1];
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end
    end

    assign timeout_c = (state_q != IDLE) && !fe && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = IDLE;
        end else if (fe) begin
            case (state_q)
                IDLE:    if (!data_s) state_d = DATA;
                DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame outputs; a good frame has stop=1 and odd weight over data+parity
    always_comb begin
        byte_v_d = 1'b0;
        err_d    = 1'b0;
        if (timeout_c) begin
            err_d = 1'b1;
        end else if (fe) begin
            case (state_q)
                IDLE: err_d = data_s;
                STOP: begin
                    if (data_s && (^{shreg_q, par_q})) byte_v_d = 1'b1;
                    else                               err_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shift register, bit counter, stall counter and registered outputs
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            byte_v    <= 1'b0;
            err       <= 1'b0;
        end else begin
            byte_v   <= byte_v_d;
            err      <= err_d;
            to_cnt_q <= ((state_q == IDLE) || fe) ? '0 : to_cnt_q + TO_W'(1);
            if (fe) begin
                case (state_q)
                    IDLE: bit_cnt_q <= '0;
                    DATA: begin
                        shreg_q   <= {data_s, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    PARITY:  par_q <= data_s;
                    default: ;
                endcase
            end
        end
    end

    assign byte_o = shreg_q;

endmodule

// File: rtl/ps2_keyb_rx.sv
// PS/2 keyboard receiver top: frame reception, E0/F0 prefix tracking,
// set-2 translation and a one-entry holding register with read handshake.
// Ports: clk_i, res_n_i (async active-low), ps2_clk_i/ps2_data_i (raw pins),
//        rx_read_i (consume), rx_data_ready_o, rx_ascii_o[7:0], rx_released_o,
//        rx_extended_o, rx_error_o (pulse), rx_overrun_o (pulse).
module ps2_keyb_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk_i,
    input  logic       res_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic       rx_read_i,
    output logic       rx_data_ready_o,
    output logic [7:0] rx_ascii_o,
    output logic       rx_released_o,
    output logic       rx_extended_o,
    output logic       rx_error_o,
    output logic       rx_overrun_o
);
    logic       byte_v;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       ext_q, brk_q;
    logic       code_c, load_c;
    logic [7:0] ascii_c;

    ps2_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame (
        .clk_i      (clk_i),
        .res_n_i    (res_n_i),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .byte_v     (byte_v),
        .byte_o     (rx_byte),
        .err        (frame_err)
    );

    assign code_c  = byte_v && (rx_byte != SC_EXT) && (rx_byte != SC_BRK);
    assign ascii_c = scan2ascii({ext_q, rx_byte});
    assign load_c  = code_c && (ascii_c != 8'h00);

    // Prefix flags: live until the next completed code or any frame error
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (frame_err || code_c) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_v) begin
            if (rx_byte == SC_EXT) ext_q <= 1'b1;
            if (rx_byte == SC_BRK) brk_q <= 1'b1;
        end
    end

    // Holding register; a same-cycle read frees the slot for the incoming code
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            rx_data_ready_o <= 1'b0;
            rx_ascii_o      <= '0;
            rx_released_o   <= 1'b0;
            rx_extended_o   <= 1'b0;
            rx_overrun_o    <= 1'b0;
        end else begin
            rx_overrun_o <= 1'b0;
            if (load_c && rx_data_ready_o && !rx_read_i) begin
                rx_overrun_o <= 1'b1;
            end else if (load_c) begin
                rx_data_ready_o <= 1'b1;
                rx_ascii_o      <= ascii_c;
                rx_released_o   <= brk_q;
                rx_extended_o   <= ext_q;
            end else if (rx_read_i) begin
                rx_data_ready_o <= 1'b0;
            end
        end
    end

    assign rx_error_o = frame_err;

endmodule
